// File: rtl/bcd_pkg.sv
// Shared types and helpers for the digit-serial BCD adder/subtractor.
package bcd_pkg;

  localparam int          BCD_DIGW      = 4;
  localparam logic [3:0]  BCD_MAX_DIGIT = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic bcd_digit_invalid(input logic [BCD_DIGW-1:0] d);
    return (d > BCD_MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd_addsub_serial_if.sv
// Operand/result bundle for bcd_addsub_serial. Master is the operand source
// and result consumer, slave is the arithmetic block.
interface bcd_addsub_serial_if
  import bcd_pkg::*;
#(
  parameter int NDIG = 3
);
  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; a source holds valid and its payload until that edge.
  logic                   in_valid;
  logic                   in_ready;
  logic [4*NDIG-1:0]      op_a;
  logic [4*NDIG-1:0]      op_b;
  logic                   sub;
  logic                   out_valid;
  logic                   out_ready;
  logic [4*NDIG-1:0]      result;
  logic                   carry_out;
  logic                   neg;
  logic                   err;
  logic                   busy;
  state_e                 dbg_state;

  modport master (
    output in_valid, op_a, op_b, sub, out_ready,
    input  in_ready, out_valid, result, carry_out, neg, err, busy, dbg_state
  );

  modport slave (
    input  in_valid, op_a, op_b, sub, out_ready,
    output in_ready, out_valid, result, carry_out, neg, err, busy, dbg_state
  );

endinterface

// File: rtl/bcd_digit_addsub.sv
// Combinational single BCD digit add/subtract with carry/borrow in and out.
module bcd_digit_addsub (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_sub,
  input  logic       i_cin,
  output logic [3:0] o_digit,
  output logic       o_cout
);

  logic [4:0] w_sum;
  logic [4:0] w_diff;

  assign w_sum  = 5'(i_a) + 5'(i_b) + 5'(i_cin);
  // Difference lies in -10..9, so bit 4 alone marks a borrow.
  assign w_diff = 5'(i_a) - 5'(i_b) - 5'(i_cin);

  always_comb begin
    o_digit = 4'd0;
    o_cout  = 1'b0;
    if (i_sub) begin
      if (w_diff[4]) begin
        o_digit = 4'(w_diff + 5'd10);
        o_cout  = 1'b1;
      end else begin
        o_digit = w_diff[3:0];
      end
    end else begin
      if (w_sum > 5'd9) begin
        o_digit = 4'(w_sum - 5'd10);
        o_cout  = 1'b1;
      end else begin
        o_digit = w_sum[3:0];
      end
    end
  end

endmodule

// File: rtl/bcd_addsub_serial.sv
// Digit-serial BCD adder/subtractor, LSD first, sign/magnitude subtraction.
// Optional BCD_ADDSUB_SATURATE_EN clamps add overflow to all nines.
module bcd_addsub_serial
  import bcd_pkg::*;
#(
  parameter int NDIG = 3
) (
  input  logic                clk,
  input  logic                rst,
  bcd_addsub_serial_if.slave  bus
);

  localparam int DW   = BCD_DIGW * NDIG;
  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [DW-1:0]     r_a;
  logic [DW-1:0]     r_b;
  logic [DW-1:0]     r_res;
  logic              r_sub;
  logic              r_c;
  logic [IDXW-1:0]   r_idx;
  logic              r_carry;
  logic              r_neg;
  logic              r_err;

  logic              w_accept;
  logic              w_in_bad;
  logic              w_last;
  logic [3:0]        w_da;
  logic [3:0]        w_db;
  logic              w_dsub;
  logic [3:0]        w_digit;
  logic              w_cout;
  logic [DW-1:0]     w_res_shift;

  always_comb begin
    w_in_bad = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_digit_invalid(bus.op_a[BCD_DIGW*i +: BCD_DIGW]) ||
          bcd_digit_invalid(bus.op_b[BCD_DIGW*i +: BCD_DIGW]))
        w_in_bad = 1'b1;
    end
  end

  assign w_accept = (r_state == IDLE) && bus.in_valid;
  assign w_last   = (r_idx == IDXW'(NDIG - 1));

  // FIX reuses the digit unit as 0 - r_i - borrow to ten's-complement r_res.
  assign w_da   = (r_state == FIX) ? 4'd0 : r_a[3:0];
  assign w_db   = (r_state == FIX) ? r_res[3:0] : r_b[3:0];
  assign w_dsub = (r_state == FIX) | r_sub;

  bcd_digit_addsub u_digit (
    .i_a     (w_da),
    .i_b     (w_db),
    .i_sub   (w_dsub),
    .i_cin   (r_c),
    .o_digit (w_digit),
    .o_cout  (w_cout)
  );

  assign w_res_shift = (r_res >> BCD_DIGW) | (DW'(w_digit) << (DW - BCD_DIGW));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (bus.in_valid) w_state_nxt = w_in_bad ? DONE : CALC;
      CALC: if (w_last) w_state_nxt = (r_sub && w_cout) ? FIX : DONE;
      FIX:  if (w_last) w_state_nxt = DONE;
      DONE: if (bus.out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_sub   <= 1'b0;
      r_c     <= 1'b0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_neg   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_a     <= bus.op_a;
          r_b     <= bus.op_b;
          r_sub   <= bus.sub;
          r_c     <= 1'b0;
          r_idx   <= '0;
          r_carry <= 1'b0;
          r_neg   <= 1'b0;
          r_err   <= w_in_bad;
          if (w_in_bad) r_res <= '0;
        end
        CALC: begin
          r_a   <= r_a >> BCD_DIGW;
          r_b   <= r_b >> BCD_DIGW;
          r_res <= w_res_shift;
          r_c   <= w_cout;
          r_idx <= r_idx + IDXW'(1);
          if (w_last) begin
            r_idx <= '0;
            if (!r_sub) begin
              r_carry <= w_cout;
`ifdef BCD_ADDSUB_SATURATE_EN
              if (w_cout) r_res <= {NDIG{BCD_MAX_DIGIT}};
`endif
            end else if (w_cout) begin
              r_neg <= 1'b1;
              r_c   <= 1'b0;
            end
          end
        end
        FIX: begin
          r_res <= w_res_shift;
          r_c   <= w_cout;
          r_idx <= w_last ? '0 : r_idx + IDXW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE) && !rst;
  assign bus.out_valid = (r_state == DONE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.result    = r_res;
  assign bus.carry_out = r_carry;
  assign bus.neg       = r_neg;
  assign bus.err       = r_err;
  assign bus.dbg_state = r_state;

endmodule
